// File: rtl/beam_sort_pkg.sv
// Shared definitions for the beam top-K selector.
//   beam_state_t : FSM encoding (IDLE -> CMP -> RANK -> SCATTER -> WRITE)
//   beam_entry_t : field layout of one result word, {idx, pwr}, sized for the
//                  widest legal configuration (COL <= 256 because indices are 8 bits)
//   rank_w/ptr_w/cnt_w : clog2-derived widths for ranks, FIFO pointers and occupancy
package beam_sort_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmp,
        StRank,
        StScatter,
        StWrite
    } beam_state_t;

    localparam int unsigned IDX_W    = 8;
    localparam int unsigned MAX_TOPK = 256;
    localparam int unsigned MAX_IW   = 64;

    // A FIFO word is packed as {idx[TOPK-1:0], pwr[TOPK-1:0]}, slot 0 in the low bits.
    typedef struct packed {
        logic [MAX_TOPK-1:0][IDX_W-1:0]  idx;
        logic [MAX_TOPK-1:0][MAX_IW-1:0] pwr;
    } beam_entry_t;

    // Rank of a beam among COL beams: 0..COL-1.
    function automatic int unsigned rank_w(input int unsigned col);
        return (col > 1) ? $clog2(col) : 1;
    endfunction

    // FIFO pointer width; pointers wrap naturally because DEPTH is a power of 2.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy needs one extra bit to represent a full FIFO.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/beam_rank_cell.sv
// Rank of one beam (IDX) among COL beams.
//   i_cmp_en  : register the "beam j beats me" vector from i_data/i_order
//   i_rank_en : register the popcount of that vector as the rank
//   i_order   : 0 = descending, 1 = ascending
//   i_data    : all COL beam powers, beam j at [j*IW +: IW]
//   o_rank    : registered rank, 0 = first in output order
// Ties go to the lower index, so the ranks of all cells form a permutation.
module beam_rank_cell
    import beam_sort_pkg::*;
#(
    parameter int unsigned IW  = 32,
    parameter int unsigned COL = 64,
    parameter int unsigned IDX = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_cmp_en,
    input  logic                   i_rank_en,
    input  logic                   i_order,
    input  logic [COL*IW-1:0]      i_data,
    output logic [rank_w(COL)-1:0] o_rank
);

    localparam int unsigned RW = rank_w(COL);

    logic [IW-1:0]  w_self;
    logic [COL-1:0] w_gt;
    logic [COL-1:0] r_gt;
    logic [RW-1:0]  w_popcnt;
    logic [RW-1:0]  r_rank;

    assign w_self = i_data[IDX*IW +: IW];

    always_comb begin
        logic [IW-1:0] v_other;
        logic          v_tie_win;
        w_gt = '0;
        for (int unsigned j = 0; j < COL; j++) begin
            v_other   = i_data[j*IW +: IW];
            v_tie_win = (v_other == w_self) && (j < IDX);
            if (j != IDX) begin
                if (i_order) begin
                    w_gt[j] = (v_other < w_self) || v_tie_win;
                end else begin
                    w_gt[j] = (v_other > w_self) || v_tie_win;
                end
            end
        end
    end

    always_comb begin
        w_popcnt = '0;
        for (int unsigned j = 0; j < COL; j++) begin
            w_popcnt = w_popcnt + RW'(r_gt[j]);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_gt   <= '0;
            r_rank <= '0;
        end else begin
            if (i_cmp_en) begin
                r_gt <= w_gt;
            end
            if (i_rank_en) begin
                r_rank <= w_popcnt;
            end
        end
    end

    assign o_rank = r_rank;

endmodule

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
//   i_clk, i_reset           : clock; reset clears only the read-data register
//   i_wr_en/i_wr_addr/i_wr_data : write port
//   i_rd_en/i_rd_addr        : read port, data appears on o_rd_data next cycle
//   o_rd_data                : holds its value until the next read
// A read and a write to the same address in one cycle return the old contents.
module sdp_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/beam_topk_select.sv
// Beam top-K selector: sorts COL beam powers of one RBG, keeps the TOPK best
// (largest or smallest per i_order) and queues {indices, powers} in a FIFO.
//   i_data/i_valid/o_ready/i_order : RBG input handshake, accepted in IDLE only
//   i_clear                        : flush FIFO, counters and any in-flight RBG
//   i_rd_en                        : pop; o_rd_index/o_rd_power/o_rd_valid next cycle
//   o_rbg_num/o_rbg_load           : written-RBG counter and per-write pulse
//   o_count/o_overflow             : FIFO occupancy and sticky drop flag
module beam_topk_select
    import beam_sort_pkg::*;
#(
    parameter int unsigned IW    = 32,
    parameter int unsigned COL   = 64,
    parameter int unsigned TOPK  = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [COL*IW-1:0]       i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_order,
    input  logic                    i_clear,
    input  logic                    i_rd_en,
    output logic [TOPK*IDX_W-1:0]   o_rd_index,
    output logic [TOPK*IW-1:0]      o_rd_power,
    output logic                    o_rd_valid,
    output logic [7:0]              o_rbg_num,
    output logic                    o_rbg_load,
    output logic [cnt_w(DEPTH)-1:0] o_count,
    output logic                    o_overflow
);

    localparam int unsigned RW = rank_w(COL);
    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned EW = TOPK * (IDX_W + IW);

    beam_state_t            r_state;
    logic [COL*IW-1:0]      r_data;
    logic                   r_order;
    logic [TOPK*IDX_W-1:0]  r_idx;
    logic [TOPK*IW-1:0]     r_pwr;
    logic [TOPK*IDX_W-1:0]  w_idx;
    logic [TOPK*IW-1:0]     w_pwr;
    logic [RW-1:0]          w_rank [COL];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [7:0]             r_rbg_num;
    logic                   r_rbg_load;
    logic                   r_overflow;
    logic                   r_rd_valid;
    logic                   w_pop;
    logic                   w_write;
    logic                   w_push;
    logic                   w_drop;
    logic [EW-1:0]          w_rd_data;

    for (genvar gi = 0; gi < COL; gi++) begin : g_cell
        beam_rank_cell #(
            .IW  (IW),
            .COL (COL),
            .IDX (gi)
        ) u_cell (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_cmp_en  (r_state == StCmp),
            .i_rank_en (r_state == StRank),
            .i_order   (r_order),
            .i_data    (r_data),
            .o_rank    (w_rank[gi])
        );
    end

    // Ranks are a permutation, so at most one beam matches each output slot.
    always_comb begin
        w_idx = '0;
        w_pwr = '0;
        for (int unsigned k = 0; k < TOPK; k++) begin
            for (int unsigned i = 0; i < COL; i++) begin
                if (w_rank[i] == RW'(k)) begin
                    w_idx[k*IDX_W +: IDX_W] = IDX_W'(i);
                    w_pwr[k*IW +: IW]       = r_data[i*IW +: IW];
                end
            end
        end
    end

    // A pop in the WRITE cycle frees the head slot, so a full FIFO still accepts.
    assign w_pop   = i_rd_en && (r_count != '0);
    assign w_write = (r_state == StWrite);
    assign w_push  = w_write && ((r_count != CW'(DEPTH)) || w_pop);
    assign w_drop  = w_write && !w_push;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_data     <= '0;
            r_order    <= 1'b0;
            r_idx      <= '0;
            r_pwr      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rbg_num  <= '0;
            r_rbg_load <= 1'b0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
        end else if (i_clear) begin
            r_state    <= StIdle;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rbg_num  <= '0;
            r_rbg_load <= 1'b0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            r_rbg_load <= w_push;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + AW'(1);
                r_rbg_num <= r_rbg_num + 8'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end

            unique case (r_state)
                StIdle: begin
                    if (i_valid) begin
                        r_data  <= i_data;
                        r_order <= i_order;
                        r_state <= StCmp;
                    end
                end
                StCmp:     r_state <= StRank;
                StRank:    r_state <= StScatter;
                StScatter: begin
                    r_idx   <= w_idx;
                    r_pwr   <= w_pwr;
                    r_state <= StWrite;
                end
                StWrite:   r_state <= StIdle;
                default:   r_state <= StIdle;
            endcase
        end
    end

    sdp_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo_ram (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (w_push && !i_clear),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({r_idx, r_pwr}),
        .i_rd_en   (w_pop && !i_clear),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign o_ready    = (r_state == StIdle);
    assign o_rd_index = w_rd_data[TOPK*IW +: TOPK*IDX_W];
    assign o_rd_power = w_rd_data[TOPK*IW-1:0];
    assign o_rd_valid = r_rd_valid;
    assign o_rbg_num  = r_rbg_num;
    assign o_rbg_load = r_rbg_load;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_beam_topk_select.sv
// Directed bench for beam_topk_select with COL=8, TOPK=4, DEPTH=4, IW=16.
module tb_beam_topk_select;

    localparam int unsigned IW    = 16;
    localparam int unsigned COL   = 8;
    localparam int unsigned TOPK  = 4;
    localparam int unsigned DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [COL*IW-1:0]    i_data = '0;
    logic                 i_valid = 1'b0;
    logic                 i_order = 1'b0;
    logic                 i_clear = 1'b0;
    logic                 i_rd_en = 1'b0;
    logic                 o_ready;
    logic [TOPK*8-1:0]    o_rd_index;
    logic [TOPK*IW-1:0]   o_rd_power;
    logic                 o_rd_valid;
    logic [7:0]           o_rbg_num;
    logic                 o_rbg_load;
    logic [2:0]           o_count;
    logic                 o_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int n_load   = 0;
    int n0;

    beam_topk_select #(
        .IW    (IW),
        .COL   (COL),
        .TOPK  (TOPK),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_order    (i_order),
        .i_clear    (i_clear),
        .i_rd_en    (i_rd_en),
        .o_rd_index (o_rd_index),
        .o_rd_power (o_rd_power),
        .o_rd_valid (o_rd_valid),
        .o_rbg_num  (o_rbg_num),
        .o_rbg_load (o_rbg_load),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_rbg_load === 1'b1) n_load++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents one RBG for a single cycle; returns just after the accept edge.
    task automatic send_rbg(input int unsigned v0, input int unsigned v1, input int unsigned v2,
                            input int unsigned v3, input int unsigned v4, input int unsigned v5,
                            input int unsigned v6, input int unsigned v7, input logic order);
        int unsigned v [COL];
        v = '{v0, v1, v2, v3, v4, v5, v6, v7};
        for (int i = 0; i < COL; i++) i_data[i*IW +: IW] = IW'(v[i]);
        i_order = order;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    // RBG r holds beams r*8+i, so its descending top 4 is idx {7,6,5,4}.
    task automatic send_seq(input int unsigned r);
        send_rbg(r*8, r*8+1, r*8+2, r*8+3, r*8+4, r*8+5, r*8+6, r*8+7, 1'b0);
    endtask

    task automatic pop();
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    function automatic logic [31:0] idx4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [63:0] pwr4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    initial begin
        ticks(2);
        check_eq("rst_ready", o_ready, 1);
        check_eq("rst_rd_valid", o_rd_valid, 0);
        check_eq("rst_load", o_rbg_load, 0);
        check_eq("rst_num", o_rbg_num, 0);
        check_eq("rst_count", o_count, 0);
        check_eq("rst_overflow", o_overflow, 0);
        check_eq("rst_index", o_rd_index, 0);
        check_eq("rst_power", o_rd_power, 0);
        rst = 1'b0;
        tick();

        // Descending sort with a tie between beams 1 and 3
        send_rbg(5, 9, 1, 9, 3, 7, 2, 8, 1'b0);
        check_eq("busy_ready", o_ready, 0);
        ticks(3);
        check_eq("load_early", o_rbg_load, 0);
        tick();
        check_eq("load_lat4", o_rbg_load, 1);
        check_eq("num_after1", o_rbg_num, 1);
        check_eq("count_after1", o_count, 1);
        check_eq("no_rd_valid", o_rd_valid, 0);
        pop();
        check_eq("desc_valid", o_rd_valid, 1);
        check_eq("desc_idx", o_rd_index, idx4(1, 3, 7, 5));
        check_eq("desc_pwr", o_rd_power, pwr4(9, 9, 8, 7));
        tick();
        check_eq("valid_pulse", o_rd_valid, 0);
        check_eq("pwr_hold", o_rd_power, pwr4(9, 9, 8, 7));

        // Ascending sort of the same data
        send_rbg(5, 9, 1, 9, 3, 7, 2, 8, 1'b1);
        ticks(4);
        pop();
        check_eq("asc_idx", o_rd_index, idx4(2, 6, 4, 0));
        check_eq("asc_pwr", o_rd_power, pwr4(1, 2, 3, 5));

        // All-equal beams: ties resolve to index order in both directions
        send_rbg(16, 16, 16, 16, 16, 16, 16, 16, 1'b0);
        ticks(4);
        pop();
        check_eq("eq_desc_idx", o_rd_index, idx4(0, 1, 2, 3));
        check_eq("eq_desc_pwr", o_rd_power, pwr4(16, 16, 16, 16));
        send_rbg(16, 16, 16, 16, 16, 16, 16, 16, 1'b1);
        ticks(4);
        pop();
        check_eq("eq_asc_idx", o_rd_index, idx4(0, 1, 2, 3));

        // Overflow: five RBGs into a four-entry FIFO
        do_clear();
        check_eq("clr_num", o_rbg_num, 0);
        check_eq("clr_count", o_count, 0);
        for (int r = 0; r < 5; r++) begin
            send_seq(r);
            ticks(4);
        end
        check_eq("drop_no_load", o_rbg_load, 0);
        check_eq("full_count", o_count, 4);
        check_eq("ovf_set", o_overflow, 1);
        check_eq("ovf_num", o_rbg_num, 4);
        for (int r = 0; r < 4; r++) begin
            pop();
            check_eq("ovf_pop_valid", o_rd_valid, 1);
            check_eq("ovf_pop_idx", o_rd_index, idx4(7, 6, 5, 4));
            check_eq("ovf_pop_pwr", o_rd_power, pwr4(r*8+7, r*8+6, r*8+5, r*8+4));
        end
        pop();
        check_eq("empty_pop_valid", o_rd_valid, 0);
        check_eq("empty_count", o_count, 0);
        check_eq("ovf_sticky", o_overflow, 1);

        // Full FIFO with a pop in the WRITE cycle: both happen, nothing dropped
        do_clear();
        check_eq("clr_ovf", o_overflow, 0);
        for (int r = 0; r < 4; r++) begin
            send_seq(r);
            ticks(4);
        end
        send_seq(4);
        ticks(3);
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
        check_eq("fullrw_load", o_rbg_load, 1);
        check_eq("fullrw_valid", o_rd_valid, 1);
        check_eq("fullrw_head", o_rd_power, pwr4(7, 6, 5, 4));
        check_eq("fullrw_count", o_count, 4);
        check_eq("fullrw_ovf", o_overflow, 0);
        check_eq("fullrw_num", o_rbg_num, 5);
        for (int r = 1; r < 5; r++) begin
            pop();
            check_eq("fullrw_pop_pwr", o_rd_power, pwr4(r*8+7, r*8+6, r*8+5, r*8+4));
        end

        // Clear while in RANK aborts the RBG and empties the FIFO
        send_seq(0);
        ticks(4);
        check_eq("pre_abort_count", o_count, 1);
        send_rbg(5, 9, 1, 9, 3, 7, 2, 8, 1'b0);
        tick();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check_eq("clr_abort_ready", o_ready, 1);
        check_eq("clr_abort_count", o_count, 0);
        n0 = n_load;
        ticks(6);
        check_eq("clr_abort_noload", 64'(n_load), 64'(n0));
        send_rbg(5, 9, 1, 9, 3, 7, 2, 8, 1'b1);
        ticks(4);
        check_eq("post_clr_count", o_count, 1);
        pop();
        check_eq("post_clr_idx", o_rd_index, idx4(2, 6, 4, 0));

        // Reset while in RANK
        send_seq(1);
        ticks(4);
        send_rbg(5, 9, 1, 9, 3, 7, 2, 8, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        check_eq("rst_abort_ready", o_ready, 1);
        check_eq("rst_abort_count", o_count, 0);
        check_eq("rst_abort_power", o_rd_power, 0);
        tick();
        rst = 1'b0;
        n0 = n_load;
        ticks(6);
        check_eq("rst_abort_noload", 64'(n_load), 64'(n0));
        send_rbg(5, 9, 1, 9, 3, 7, 2, 8, 1'b0);
        ticks(4);
        pop();
        check_eq("post_rst_idx", o_rd_index, idx4(1, 3, 7, 5));
        check_eq("post_rst_pwr", o_rd_power, pwr4(9, 9, 8, 7));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/beam_topk_select.md
BEAM_TOPK_SELECT -- requirements
Module: beam_topk_select

Interface
REQ-001 SHALL have parameter IW, default 32: unsigned beam power width.
REQ-002 SHALL have parameter COL, default 64: number of beams per RBG, a power of 2, at least 2.
REQ-003 SHALL have parameter TOPK, default 16: number of selected beams, 1..COL.
REQ-004 SHALL have parameter DEPTH, default 16: result FIFO entries, a power of 2.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port i_data, input, COL x IW bits: beam powers for one RBG.
REQ-008 SHALL have port i_valid, input, 1 bit: i_data valid.
REQ-009 SHALL have port o_ready, output, 1 bit: block can accept an RBG.
REQ-010 SHALL have port i_order, input, 1 bit: 0 = descending (largest first), 1 = ascending.
REQ-011 SHALL have port i_clear, input, 1 bit: synchronous flush of the FIFO and counters (symbol start).
REQ-012 SHALL have port i_rd_en, input, 1 bit: pop one result.
REQ-013 SHALL have port o_rd_index, output, TOPK x 8 bits: sorted beam indices.
REQ-014 SHALL have port o_rd_power, output, TOPK x IW bits: sorted beam powers.
REQ-015 SHALL have port o_rd_valid, output, 1 bit: o_rd_index and o_rd_power valid for one cycle.
REQ-016 SHALL have port o_rbg_num, output, 8 bits: count of RBGs written since clear.
REQ-017 SHALL have port o_rbg_load, output, 1 bit: one-cycle pulse per FIFO write.
REQ-018 SHALL have port o_count, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-019 SHALL have port o_overflow, output, 1 bit: sticky flag, set when a result is dropped.

Function
REQ-020 SHALL accept an RBG on i_valid && o_ready, capturing i_data and i_order together.
REQ-021 SHALL drive o_ready = (state == IDLE).
REQ-022 SHALL sequence the FSM IDLE -> CMP -> RANK -> SCATTER -> WRITE -> IDLE, one cycle per state, with no stalls.
REQ-023 SHALL, in CMP, register the comparison bit gt[i][j] for each j != i: descending = d[j] > d[i] or (d[j] == d[i] and j < i); ascending = d[j] < d[i] or (d[j] == d[i] and j < i); unsigned compare.
REQ-024 SHALL, in RANK, register rank[i] = popcount(gt[i]), width clog2(COL); ranks form a permutation of 0..COL-1.
REQ-025 SHALL, in SCATTER, for each beam i with rank[i] < TOPK, set idx[rank[i]] = i and pwr[rank[i]] = d[i]; beams with rank >= TOPK are discarded.
REQ-026 SHALL, in WRITE, push {idx, pwr} to the FIFO, pulse o_rbg_load, and increment o_rbg_num, which wraps at 255.
REQ-027 SHALL have a latency of 4 cycles from the accept edge to the o_rbg_load pulse; throughput is one RBG per 5 cycles.
REQ-028 SHALL, on i_rd_en with o_count > 0, present the head entry with o_rd_valid the next cycle (1-cycle latency) and advance the read pointer, which wraps at DEPTH.
REQ-029 SHALL ignore i_rd_en when the FIFO is empty: o_rd_valid stays 0 and no state changes.
REQ-030 SHALL, on a WRITE with o_count == DEPTH and no same-cycle pop, drop the entry, set o_overflow, skip o_rbg_load, and hold o_rbg_num.
REQ-031 SHALL, on a WRITE and a valid pop in the same cycle, accept both, including when the FIFO is full; o_count is unchanged.
REQ-032 SHALL, on i_clear, zero the pointers, o_count, o_rbg_num and o_overflow, and abort any in-flight RBG so the FSM returns to IDLE.
REQ-033 SHALL give i_clear priority over every other event in the same cycle.
REQ-034 SHALL hold o_rd_index and o_rd_power between pops; only o_rd_valid qualifies them.

Reset
REQ-035 SHALL, while i_reset is high, force: state IDLE (o_ready = 1), o_rd_valid = 0, o_rbg_load = 0, o_rbg_num = 0, o_count = 0, o_overflow = 0, o_rd_index = 0, o_rd_power = 0.
REQ-036 SHALL treat reset asserted mid-operation as discarding the in-flight RBG and all FIFO contents; FIFO RAM content need not be cleared.

Structure
REQ-037 SHALL place the FSM state enum, the idx/pwr entry struct, and the CLOG2-derived width constants in a shared package, beam_sort_pkg.
REQ-038 SHALL implement the per-beam compare-and-popcount as one sub-module, beam_rank_cell, instantiated COL times.
REQ-039 SHALL hold the FIFO storage in the team's simple dual-port RAM wrapper, width TOPK*(8+IW), depth DEPTH.

Verification
REQ-040 SHALL cover: COL=8, TOPK=4, descending, d = {5,9,1,9,3,7,2,8} -> idx {1,3,7,5}, pwr {9,9,8,7}, o_rbg_load 4 cycles after accept.
REQ-041 SHALL cover: the same data with i_order=1 -> idx {2,6,4,0}, pwr {1,2,3,5}.
REQ-042 SHALL cover: all beams equal to 0x10 -> idx {0,1,2,3} in both orders.
REQ-043 SHALL cover: DEPTH=4, 5 RBGs pushed with no reads -> o_count=4, o_overflow=1, o_rbg_num=4; then 4 pops return RBGs 0..3 in order and a 5th pop gives no o_rd_valid.
REQ-044 SHALL cover: FIFO full with i_rd_en asserted in the WRITE cycle -> no overflow, o_count stays 4, o_rbg_num increments.
REQ-045 SHALL cover: i_clear or i_reset asserted in the RANK state -> next cycle o_ready=1, o_count=0, no o_rbg_load; the next RBG sorts correctly.
